// File: rtl/mpsk_qam_stream_mapper_if.sv
// Stream bundle for the BPSK/QPSK/16-QAM mapper: word input side, I/Q symbol output side, busy flag.
// Handshakes: a transfer happens on a rising edge where valid && ready; the sender holds data stable
// while valid && !ready, and the receiver may raise or lower ready at any time.
interface mpsk_qam_stream_mapper_if #(
  parameter int IN_W   = 8,
  parameter int DATA_W = 16
);
  logic [1:0]               mode;
  logic [IN_W-1:0]          in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] out_i;
  logic signed [DATA_W-1:0] out_q;
  logic                     out_valid;
  logic                     out_ready;
  logic                     busy;

  modport slave (
    input  mode, in_data, in_valid, out_ready,
    output in_ready, out_i, out_q, out_valid, busy
  );

  modport master (
    output mode, in_data, in_valid, out_ready,
    input  in_ready, out_i, out_q, out_valid, busy
  );
endinterface

// File: rtl/mpsk_qam_stream_mapper.sv
// Serialises IN_W-bit words LSB-first into BPSK/QPSK/16-QAM symbols and emits Gray-mapped I/Q.
// Mode is latched per word; output register holds its symbol under backpressure.
module mpsk_qam_stream_mapper #(
  parameter int IN_W   = 8,
  parameter int DATA_W = 16,
  parameter int AMP    = 23170,
  parameter int AMP_LO = AMP / 3
) (
  input  logic                     clk,
  input  logic                     rst,
  mpsk_qam_stream_mapper_if.slave  bus
);
  localparam int CW = $clog2(IN_W + 1);
  localparam logic signed [DATA_W-1:0] P_HI = DATA_W'(AMP);
  localparam logic signed [DATA_W-1:0] N_HI = DATA_W'(-AMP);
  localparam logic signed [DATA_W-1:0] P_LO = DATA_W'(AMP_LO);
  localparam logic signed [DATA_W-1:0] N_LO = DATA_W'(-AMP_LO);

  logic [IN_W-1:0]          sr_q, sr_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [1:0]               mode_q;
  logic signed [DATA_W-1:0] out_i_q, out_q_q, out_i_d, out_q_d;
  logic                     out_valid_q;
  logic [CW-1:0]            bps;
  logic [3:0]               sym;
  logic                     adv, accept;

  // Per-axis Gray level for bit pair {s,m}: s selects sign, m selects inner level.
  function automatic logic signed [DATA_W-1:0] lvl(input logic s, input logic m);
    case ({s, m})
      2'b00:   return P_HI;
      2'b01:   return P_LO;
      2'b11:   return N_LO;
      default: return N_HI;
    endcase
  endfunction

  always_comb begin
    case (mode_q)
      2'b00:   bps = CW'(1);
      2'b10:   bps = CW'(4);
      default: bps = CW'(2);
    endcase
  end

  always_comb begin
    sym     = sr_q[3:0];
    out_i_d = lvl(sym[0], 1'b0);
    out_q_d = '0;
    case (mode_q)
      2'b00: ;
      2'b10: begin
        out_i_d = lvl(sym[1], sym[0]);
        out_q_d = lvl(sym[3], sym[2]);
      end
      default: out_q_d = lvl(sym[1], 1'b0);
    endcase
  end

  assign sr_d  = sr_q >> bps;
  assign cnt_d = cnt_q - bps;
  assign adv   = (cnt_q != '0) && (!out_valid_q || bus.out_ready);

  // in_ready looks through out_ready so the next word is taken on the edge that issues the last symbol.
  assign bus.in_ready  = (cnt_q == '0) || ((cnt_q == bps) && adv);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_i     = out_i_q;
  assign bus.out_q     = out_q_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (cnt_q != '0) || out_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q        <= '0;
      cnt_q       <= '0;
      mode_q      <= '0;
      out_i_q     <= '0;
      out_q_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (adv) begin
        sr_q        <= sr_d;
        cnt_q       <= cnt_d;
        out_i_q     <= out_i_d;
        out_q_q     <= out_q_d;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept) begin
        sr_q   <= bus.in_data;
        cnt_q  <= CW'(IN_W);
        mode_q <= bus.mode;
      end
    end
  end
endmodule
